// File: rtl/axil2native_adapter.sv
// AXI4-Lite slave to native-bus master bridge: one native request per accepted
// AXI-Lite read or write, with AW/W buffering and held B/R responses.
module axil2native_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  native_valid,
    output logic                  native_instr,
    input  logic                  native_ready,
    output logic [ADDR_WIDTH-1:0] native_addr,
    output logic [DATA_WIDTH-1:0] native_wdata,
    output logic [STRB_WIDTH-1:0] native_wstrb,
    input  logic [DATA_WIDTH-1:0] native_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WRESP, RRESP} state_t;

    state_t                state_q, state_d;
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic                  prefer_rd_q, prefer_rd_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  nvalid_q, nvalid_d;
    logic                  ninstr_q, ninstr_d;
    logic [ADDR_WIDTH-1:0] naddr_q, naddr_d;
    logic [DATA_WIDTH-1:0] nwdata_q, nwdata_d;
    logic [STRB_WIDTH-1:0] nwstrb_q, nwstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_ready;
    logic                  unused_prot;

    assign unused_prot   = ^{s_axi_awprot, s_axi_arprot[1:0]};
    assign write_ready   = aw_full_q && w_full_q;

    // A buffered write blocks reads only when it is the write's turn to win
    assign s_axi_awready = !aw_full_q;
    assign s_axi_wready  = !w_full_q;
    assign s_axi_arready = (state_q == IDLE) && (!write_ready || prefer_rd_q);

    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign native_valid  = nvalid_q;
    assign native_instr  = ninstr_q;
    assign native_addr   = naddr_q;
    assign native_wdata  = nwdata_q;
    assign native_wstrb  = nwstrb_q;

    always_comb begin
        state_d     = state_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        prefer_rd_d = prefer_rd_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        nvalid_d    = nvalid_q;
        ninstr_d    = ninstr_q;
        naddr_d     = naddr_q;
        nwdata_d    = nwdata_q;
        nwstrb_d    = nwstrb_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;

        if (s_axi_awvalid && !aw_full_q) begin
            aw_full_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (s_axi_wvalid && !w_full_q) begin
            w_full_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end

        case (state_q)
            IDLE: begin
                if (write_ready && !(prefer_rd_q && s_axi_arvalid)) begin
                    state_d  = WRITE;
                    nvalid_d = 1'b1;
                    naddr_d  = awaddr_q;
                    nwdata_d = wdata_q;
                    nwstrb_d = wstrb_q;
                    ninstr_d = 1'b0;
                end else if (s_axi_arvalid && s_axi_arready) begin
                    state_d  = READ;
                    nvalid_d = 1'b1;
                    naddr_d  = s_axi_araddr;
                    nwstrb_d = '0;
                    ninstr_d = s_axi_arprot[2];
                end
            end
            WRITE: begin
                if (native_ready) begin
                    state_d     = WRESP;
                    nvalid_d    = 1'b0;
                    bvalid_d    = 1'b1;
                    aw_full_d   = 1'b0;
                    w_full_d    = 1'b0;
                    prefer_rd_d = 1'b1;
                end
            end
            READ: begin
                if (native_ready) begin
                    state_d     = RRESP;
                    nvalid_d    = 1'b0;
                    rvalid_d    = 1'b1;
                    rdata_d     = native_rdata;
                    prefer_rd_d = 1'b0;
                end
            end
            WRESP: begin
                if (s_axi_bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            RRESP: begin
                if (s_axi_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any in-flight native request and discards buffered AW/W
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            prefer_rd_q <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            nvalid_q    <= 1'b0;
            ninstr_q    <= 1'b0;
            naddr_q     <= '0;
            nwdata_q    <= '0;
            nwstrb_q    <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            prefer_rd_q <= prefer_rd_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            nvalid_q    <= nvalid_d;
            ninstr_q    <= ninstr_d;
            naddr_q     <= naddr_d;
            nwdata_q    <= nwdata_d;
            nwstrb_q    <= nwstrb_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axil2native_adapter.sv
// Directed testbench for axil2native_adapter: inputs change and outputs are
// sampled 1ns after each rising edge, with hand-computed expectations.
module tb_axil2native_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;
    logic        nvalid, ninstr, nready;
    logic [31:0] naddr, nwdata, nrdata;
    logic [3:0]  nwstrb;
    int          checks = 0;
    int          errors = 0;

    axil2native_adapter dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awprot(awprot), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_bresp(bresp), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .native_valid(nvalid), .native_instr(ninstr),
        .native_ready(nready), .native_addr(naddr), .native_wdata(nwdata),
        .native_wstrb(nwstrb), .native_rdata(nrdata)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; arprot = 0; rready = 0;
        nready = 0; nrdata = 0;
        step; step;
        rst = 1'b0;
        checks++; if (nvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_nvalid: got %0h expected 0", nvalid); end
        checks++; if ({ninstr, naddr, nwdata, nwstrb} !== '0) begin errors++; $display("[TB] FAIL reset_native: got %0h expected 0", {ninstr, naddr, nwdata, nwstrb}); end
        checks++; if ({bvalid, rvalid, rdata} !== '0) begin errors++; $display("[TB] FAIL reset_resp: got %0h expected 0", {bvalid, rvalid, rdata}); end
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 111", {awready, wready, arready}); end
        checks++; if ({bresp, rresp} !== 4'b0) begin errors++; $display("[TB] FAIL reset_resp_codes: got %b expected 0000", {bresp, rresp}); end
    endtask

    task automatic test_single_write;
        awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        step;
        awvalid = 0; wvalid = 0;
        checks++; if ({nvalid, awready, wready} !== 3'b000) begin errors++; $display("[TB] FAIL wr_capture: got %b expected 000", {nvalid, awready, wready}); end
        step;
        checks++; if (nvalid !== 1'b1) begin errors++; $display("[TB] FAIL wr_nvalid: got %0h expected 1", nvalid); end
        checks++; if ({naddr, nwdata, nwstrb, ninstr} !== {32'h10, 32'hDEADBEEF, 4'hF, 1'b0}) begin errors++; $display("[TB] FAIL wr_fields: got %0h expected %0h", {naddr, nwdata, nwstrb, ninstr}, {32'h10, 32'hDEADBEEF, 4'hF, 1'b0}); end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if ({nvalid, naddr} !== {1'b1, 32'h10}) begin errors++; $display("[TB] FAIL wr_hold: got %0h expected %0h", {nvalid, naddr}, {1'b1, 32'h10}); end
        end
        nready = 1;
        step;
        nready = 0;
        checks++; if ({nvalid, bvalid, bresp} !== 4'b0100) begin errors++; $display("[TB] FAIL wr_bvalid: got %b expected 0100", {nvalid, bvalid, bresp}); end
        checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("[TB] FAIL wr_flags_clear: got %b expected 11", {awready, wready}); end
        bready = 1;
        step;
        bready = 0;
        checks++; if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_bdone: got %0h expected 0", bvalid); end
    endtask

    task automatic test_single_read;
        arvalid = 1; araddr = 32'h20; arprot = 3'b100;
        checks++; if (arready !== 1'b1) begin errors++; $display("[TB] FAIL rd_arready: got %0h expected 1", arready); end
        step;
        arvalid = 0; arprot = 0;
        checks++; if ({nvalid, ninstr, nwstrb, naddr} !== {1'b1, 1'b1, 4'h0, 32'h20}) begin errors++; $display("[TB] FAIL rd_native: got %0h expected %0h", {nvalid, ninstr, nwstrb, naddr}, {1'b1, 1'b1, 4'h0, 32'h20}); end
        nready = 1; nrdata = 32'h12345678;
        step;
        nready = 0; nrdata = 32'h0;
        checks++; if ({nvalid, rvalid, rresp} !== 4'b0100) begin errors++; $display("[TB] FAIL rd_rvalid: got %b expected 0100", {nvalid, rvalid, rresp}); end
        checks++; if (rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL rd_rdata: got %0h expected 12345678", rdata); end
        rready = 1;
        step;
        rready = 0;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rdone: got %0h expected 0", rvalid); end
    endtask

    task automatic test_split_write;
        wvalid = 1; wdata = 32'hAAAA5555; wstrb = 4'h3;
        step;
        wvalid = 0;
        checks++; if ({wready, awready} !== 2'b01) begin errors++; $display("[TB] FAIL split_w_first: got %b expected 01", {wready, awready}); end
        step; step; step;
        checks++; if (nvalid !== 1'b0) begin errors++; $display("[TB] FAIL split_no_launch: got %0h expected 0", nvalid); end
        awvalid = 1; awaddr = 32'h34;
        wvalid = 1; wdata = 32'hBBBB0000; wstrb = 4'hC;
        checks++; if (wready !== 1'b0) begin errors++; $display("[TB] FAIL split_w2_blocked: got %0h expected 0", wready); end
        step;
        awvalid = 0;
        checks++; if ({nvalid, wready} !== 2'b00) begin errors++; $display("[TB] FAIL split_gap: got %b expected 00", {nvalid, wready}); end
        step;
        checks++; if ({nvalid, naddr, nwdata, nwstrb} !== {1'b1, 32'h34, 32'hAAAA5555, 4'h3}) begin errors++; $display("[TB] FAIL split_native: got %0h expected %0h", {nvalid, naddr, nwdata, nwstrb}, {1'b1, 32'h34, 32'hAAAA5555, 4'h3}); end
        nready = 1;
        step;
        nready = 0;
        checks++; if ({bvalid, wready} !== 2'b11) begin errors++; $display("[TB] FAIL split_w2_accept: got %b expected 11", {bvalid, wready}); end
        step;
        wvalid = 0;
        checks++; if ({wready, awready} !== 2'b01) begin errors++; $display("[TB] FAIL split_w2_held: got %b expected 01", {wready, awready}); end
        bready = 1;
        step;
        bready = 0;
        awvalid = 1; awaddr = 32'h44;
        step;
        awvalid = 0;
        step;
        checks++; if ({nvalid, naddr, nwdata, nwstrb} !== {1'b1, 32'h44, 32'hBBBB0000, 4'hC}) begin errors++; $display("[TB] FAIL split_second: got %0h expected %0h", {nvalid, naddr, nwdata, nwstrb}, {1'b1, 32'h44, 32'hBBBB0000, 4'hC}); end
        nready = 1;
        step;
        nready = 0;
        checks++; if (bvalid !== 1'b1) begin errors++; $display("[TB] FAIL split_second_b: got %0h expected 1", bvalid); end
        bready = 1;
        step;
        bready = 0;
    endtask

    task automatic test_contention;
        logic [31:0] wa, wd, ra, rd;
        arvalid = 1; araddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            wa = 32'h100 + 32'(16 * k);
            wd = 32'hA0000000 + 32'(k);
            ra = 32'h200 + 32'(16 * k);
            rd = 32'h50000000 + 32'(k);
            awvalid = 1; awaddr = wa; wvalid = 1; wdata = wd; wstrb = 4'hF;
            checks++; if (arready !== 1'b1) begin errors++; $display("[TB] FAIL cont_rd_turn%0d: got %0h expected 1", k, arready); end
            step;
            awvalid = 0; wvalid = 0; arvalid = 0;
            checks++; if ({nvalid, naddr, nwstrb} !== {1'b1, ra, 4'h0}) begin errors++; $display("[TB] FAIL cont_rd_first%0d: got %0h expected %0h", k, {nvalid, naddr, nwstrb}, {1'b1, ra, 4'h0}); end
            nready = 1; nrdata = rd;
            step;
            nready = 0; nrdata = 0;
            checks++; if ({rvalid, rdata} !== {1'b1, rd}) begin errors++; $display("[TB] FAIL cont_rdata%0d: got %0h expected %0h", k, {rvalid, rdata}, {1'b1, rd}); end
            rready = 1;
            step;
            rready = 0;
            if (k < 3) begin
                arvalid = 1; araddr = ra + 32'h10;
            end
            checks++; if (arready !== 1'b0) begin errors++; $display("[TB] FAIL cont_wr_turn%0d: got %0h expected 0", k, arready); end
            step;
            checks++; if ({nvalid, naddr, nwdata} !== {1'b1, wa, wd}) begin errors++; $display("[TB] FAIL cont_wr_second%0d: got %0h expected %0h", k, {nvalid, naddr, nwdata}, {1'b1, wa, wd}); end
            nready = 1;
            step;
            nready = 0;
            checks++; if (bvalid !== 1'b1) begin errors++; $display("[TB] FAIL cont_b%0d: got %0h expected 1", k, bvalid); end
            bready = 1;
            step;
            bready = 0;
        end
    endtask

    task automatic test_backpressure;
        arvalid = 1; araddr = 32'h300; arprot = 3'b000;
        step;
        arvalid = 0;
        checks++; if ({nvalid, ninstr} !== 2'b10) begin errors++; $display("[TB] FAIL bp_native: got %b expected 10", {nvalid, ninstr}); end
        nready = 1; nrdata = 32'hCAFEF00D;
        step;
        nready = 0; nrdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                awvalid = 1; awaddr = 32'h80; wvalid = 1; wdata = 32'h11112222; wstrb = 4'hF;
            end
            checks++; if ({rvalid, rdata, nvalid} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin errors++; $display("[TB] FAIL bp_hold%0d: got %0h expected %0h", i, {rvalid, rdata, nvalid}, {1'b1, 32'hCAFEF00D, 1'b0}); end
            step;
            awvalid = 0; wvalid = 0;
        end
        rready = 1;
        step;
        rready = 0;
        checks++; if ({rvalid, nvalid} !== 2'b00) begin errors++; $display("[TB] FAIL bp_gap: got %b expected 00", {rvalid, nvalid}); end
        step;
        checks++; if ({nvalid, naddr, nwdata} !== {1'b1, 32'h80, 32'h11112222}) begin errors++; $display("[TB] FAIL bp_write_after: got %0h expected %0h", {nvalid, naddr, nwdata}, {1'b1, 32'h80, 32'h11112222}); end
        nready = 1;
        step;
        nready = 0;
        bready = 1;
        step;
        bready = 0;
    endtask

    task automatic test_reset_mid;
        awvalid = 1; awaddr = 32'h90; wvalid = 1; wdata = 32'h77778888; wstrb = 4'hF;
        step;
        awvalid = 0; wvalid = 0;
        step;
        checks++; if (nvalid !== 1'b1) begin errors++; $display("[TB] FAIL rm_launch: got %0h expected 1", nvalid); end
        rst = 1;
        step;
        rst = 0;
        checks++; if ({nvalid, ninstr, naddr, nwdata, nwstrb, bvalid, rvalid, rdata} !== '0) begin errors++; $display("[TB] FAIL rm_outputs: got %0h expected 0", {nvalid, ninstr, naddr, nwdata, nwstrb, bvalid, rvalid, rdata}); end
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("[TB] FAIL rm_flags: got %b expected 111", {awready, wready, arready}); end
        step; step;
        checks++; if (nvalid !== 1'b0) begin errors++; $display("[TB] FAIL rm_discarded: got %0h expected 0", nvalid); end
        arvalid = 1; araddr = 32'h40;
        step;
        arvalid = 0;
        checks++; if ({nvalid, naddr} !== {1'b1, 32'h40}) begin errors++; $display("[TB] FAIL rm_read: got %0h expected %0h", {nvalid, naddr}, {1'b1, 32'h40}); end
        nready = 1; nrdata = 32'h0BADF00D;
        step;
        nready = 0; nrdata = 0;
        checks++; if ({rvalid, rdata} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("[TB] FAIL rm_rdata: got %0h expected %0h", {rvalid, rdata}, {1'b1, 32'h0BADF00D}); end
        rready = 1;
        step;
        rready = 0;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rm_rdone: got %0h expected 0", rvalid); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_split_write();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil2native_adapter.md
Name: axil2native_adapter

Overview:
- AXI4-Lite slave to native-bus master bridge.
- Sits directly downstream of an AXI4-Lite master port, such as the native-to-AXI-Lite adapter output or an AXI-Lite interconnect.
- Presents each accepted AXI-Lite read or write as one native transaction: valid is held until ready.
- Buffers independent AW/W arrival; holds B/R responses until the master accepts them.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- s_axi_awvalid  input  1  write address valid.
- s_axi_awready  output  1  write address ready.
- s_axi_awaddr  input  ADDR_WIDTH  write address.
- s_axi_awprot  input  3  ignored.
- s_axi_wvalid  input  1  write data valid.
- s_axi_wready  output  1  write data ready.
- s_axi_wdata  input  DATA_WIDTH  write data.
- s_axi_wstrb  input  STRB_WIDTH  write strobes.
- s_axi_bvalid  output  1  write response valid.
- s_axi_bready  input  1  write response ready.
- s_axi_bresp  output  2  constant 2'b00 (OKAY).
- s_axi_arvalid  input  1  read address valid.
- s_axi_arready  output  1  read address ready.
- s_axi_araddr  input  ADDR_WIDTH  read address.
- s_axi_arprot  input  3  bit 2 marks an instruction fetch.
- s_axi_rvalid  output  1  read data valid.
- s_axi_rready  input  1  read data ready.
- s_axi_rdata  output  DATA_WIDTH  read data.
- s_axi_rresp  output  2  constant 2'b00 (OKAY).
- native_valid  output  1  native request valid.
- native_instr  output  1  instruction fetch flag.
- native_ready  input  1  one-cycle completion pulse.
- native_addr  output  ADDR_WIDTH  request address.
- native_wdata  output  DATA_WIDTH  write data.
- native_wstrb  output  STRB_WIDTH  write strobes; all-zero means read.
- native_rdata  input  DATA_WIDTH  read data, valid while native_ready is high.

Behaviour:
- Reset values:
  - state = IDLE, aw_full = 0, w_full = 0, prefer_rd = 0.
  - All outputs 0: native_valid, native_instr, native_addr, native_wdata, native_wstrb, s_axi_bvalid, s_axi_rvalid, s_axi_rdata.
  - Reset mid-transaction aborts it: native_valid drops the next cycle and captured AW/W contents are discarded.
- AW/W capture:
  - s_axi_awready = !aw_full; a handshake latches awaddr and sets aw_full.
  - s_axi_wready = !w_full; a handshake latches wdata/wstrb and sets w_full.
  - AW and W are independent; either may arrive first, any gap allowed.
  - Both flags clear on the cycle the native write completes.
- State machine (registered outputs; IDLE decisions use registered flags only):
  - IDLE -> WRITE when aw_full && w_full && !(prefer_rd && s_axi_arvalid).
    - native_valid = 1, native_addr = awaddr, native_wdata/native_wstrb = captured values, native_instr = 0.
  - s_axi_arready = (state == IDLE) && (!(aw_full && w_full) || prefer_rd). It is combinational on state and flags.
  - IDLE -> READ on an AR handshake.
    - native_valid = 1, native_addr = araddr, native_wstrb = 0, native_instr = arprot[2].
  - WRITE: on native_ready = 1 -> WRESP.
    - native_valid = 0, s_axi_bvalid = 1, flags clear, prefer_rd = 1.
  - READ: on native_ready = 1 -> RRESP.
    - native_valid = 0, s_axi_rdata = native_rdata (registered), s_axi_rvalid = 1, prefer_rd = 0.
  - WRESP: bvalid held until bready = 1 -> IDLE, bvalid = 0.
  - RRESP: rvalid and rdata held stable until rready = 1 -> IDLE, rvalid = 0.
- native_valid and native_addr/wdata/wstrb/instr stay stable from assertion until the native_ready cycle. native_ready is ignored when native_valid = 0.
- Latency:
  - Read: AR handshake in cycle N -> native_valid from N+1. native_ready in cycle M -> rvalid from M+1.
  - Write: later of the AW/W handshakes in cycle N -> native_valid from N+2. native_ready in cycle M -> bvalid from M+1.
  - Minimum gap from response handshake to next native_valid is 1 cycle in IDLE.
- Concurrency and ordering:
  - AW/W for the next write may be captured while READ/RRESP/WRESP is active, one slot each.
  - At most one native transaction is outstanding.
- Arbitration: when a complete write and an arvalid are both present in IDLE, prefer_rd selects the winner, so grants alternate and neither direction starves.

Test Plan:
- Single write: AW+W same cycle (addr 0x10, data 0xDEADBEEF, strb 0xF), native_ready 3 cycles after native_valid -> native write with those values; bvalid 1 cycle after native_ready; bresp = 0.
- Single read: AR addr 0x20, arprot = 3'b100; native_ready with rdata 0x12345678 -> native_instr = 1, native_wstrb = 0; rvalid next cycle with rdata 0x12345678.
- Split write: W 4 cycles before AW, then a second W while the first is pending -> wready low for the second W until the first write completes; native_valid 2 cycles after the AW handshake.
- Contention: complete write captured with arvalid held after a previous write -> read granted first, then the write; alternation holds over 4 back-to-back pairs.
- Backpressure: rready low 5 cycles -> rvalid/rdata stable; no new native_valid until after the rready handshake.
- Reset mid-transaction: rst during WRITE with native_valid high -> next cycle all outputs 0 and flags clear; a subsequent read completes normally.
